// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with all-red clearance, pedestrian walk phase
// and maintenance flashing-yellow mode. Timing is counted in clk_1s cycles.
module traffic_light_ctrl #(
  parameter int CNT_W    = 6,
  parameter int GREEN1_T = 40,
  parameter int GREEN2_T = 20,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10
) (
  input  logic             clk_1s,
  input  logic             rst,
  input  logic             flash_en,
  input  logic             ped_req,
  output logic             green_1,
  output logic             yellow_1,
  output logic             red_1,
  output logic             green_2,
  output logic             yellow_2,
  output logic             red_2,
  output logic             walk,
  output logic             ped_ack,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] remain_o
);

  localparam longint TMAX = longint'(1) << CNT_W;

  if (GREEN1_T < 1 || GREEN1_T > TMAX || GREEN2_T < 1 || GREEN2_T > TMAX ||
      YELLOW_T < 1 || YELLOW_T > TMAX || ALLRED_T < 1 || ALLRED_T > TMAX ||
      WALK_T < 1 || WALK_T > TMAX) begin : g_bad_param
    $fatal(1, "traffic_light_ctrl: phase durations must lie in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] G1_LAST   = CNT_W'(GREEN1_T - 1);
  localparam logic [CNT_W-1:0] G2_LAST   = CNT_W'(GREEN2_T - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

  typedef enum logic [2:0] {
    S_G1    = 3'd0,
    S_Y1    = 3'd1,
    S_AR1   = 3'd2,
    S_G2    = 3'd3,
    S_Y2    = 3'd4,
    S_AR2   = 3'd5,
    S_WALK  = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, last;
  logic             ped_pending, blink;
  logic             phase_done, enter_walk, accept;

  always_comb begin
    last = '0;
    unique case (state)
      S_G1:         last = G1_LAST;
      S_Y1, S_Y2:   last = YEL_LAST;
      S_AR1, S_AR2: last = AR_LAST;
      S_G2:         last = G2_LAST;
      S_WALK:       last = WALK_LAST;
      default:      last = '0;
    endcase
  end

  assign phase_done = (state != S_FLASH) && (cnt == last);

  // flash_en only matters at the all-red exits so a running phase is never cut short
  always_comb begin
    state_nxt = state;
    if (state == S_FLASH) begin
      if (!flash_en) state_nxt = S_AR2;
    end else if (phase_done) begin
      unique case (state)
        S_G1:    state_nxt = S_Y1;
        S_Y1:    state_nxt = S_AR1;
        S_AR1:   state_nxt = flash_en ? S_FLASH : S_G2;
        S_G2:    state_nxt = S_Y2;
        S_Y2:    state_nxt = S_AR2;
        S_AR2:   state_nxt = flash_en ? S_FLASH : (ped_pending ? S_WALK : S_G1);
        S_WALK:  state_nxt = S_G1;
        default: state_nxt = S_G1;
      endcase
    end
  end

  assign cnt_nxt    = (state_nxt != state || state == S_FLASH) ? '0 : cnt + CNT_W'(1);
  assign enter_walk = (state_nxt == S_WALK) && (state != S_WALK);
  assign accept     = ped_req && !ped_pending && (state != S_WALK) && !enter_walk;

  always_ff @(posedge clk_1s or posedge rst) begin
    if (rst) begin
      state       <= S_G1;
      cnt         <= '0;
      ped_pending <= 1'b0;
      blink       <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      blink       <= (state == S_FLASH && state_nxt == S_FLASH) ? ~blink : 1'b0;
      ped_ack     <= accept;
      ped_pending <= enter_walk ? 1'b0 : (accept ? 1'b1 : ped_pending);
    end
  end

  always_comb begin
    green_1  = 1'b0;
    yellow_1 = 1'b0;
    red_1    = 1'b0;
    green_2  = 1'b0;
    yellow_2 = 1'b0;
    red_2    = 1'b0;
    walk     = 1'b0;
    unique case (state)
      S_G1:  begin green_1  = 1'b1; red_2    = 1'b1; end
      S_Y1:  begin yellow_1 = 1'b1; red_2    = 1'b1; end
      S_G2:  begin red_1    = 1'b1; green_2  = 1'b1; end
      S_Y2:  begin red_1    = 1'b1; yellow_2 = 1'b1; end
      S_AR1, S_AR2: begin red_1 = 1'b1; red_2 = 1'b1; end
      S_WALK: begin red_1   = 1'b1; red_2    = 1'b1; walk = 1'b1; end
      S_FLASH: begin yellow_1 = blink; yellow_2 = blink; end
      default: begin green_1 = 1'b1; red_2 = 1'b1; end
    endcase
  end

  assign state_o  = state;
  assign remain_o = (state == S_FLASH) ? '0 : last - cnt;

endmodule
